// File: rtl/i2c_dispatch_pkg.sv
// Shared definitions for the I2C command dispatcher: FSM states, STATUS layout
// and command-record field positions.
package i2c_dispatch_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_DEV,
        S_LD_NB,
        S_LD_ADDR,
        S_LOAD,
        S_EXEC,
        S_WAIT,
        S_DRAIN,
        S_DONE,
        S_HOLD
    } state_t;

    localparam int ST_BUSY     = 0;
    localparam int ST_WEMPTY   = 1;
    localparam int ST_WFULL    = 2;
    localparam int ST_REMPTY   = 3;
    localparam int ST_RFULL    = 4;
    localparam int ST_ERR_FMT  = 5;
    localparam int ST_ERR_NACK = 6;
    localparam int ST_ERR_TMO  = 7;

    localparam int N_HI     = 7;
    localparam int N_LO     = 4;
    localparam int READ_BIT = 3;

    // Engines need a couple of cycles after EXECUTE before READY drops.
    localparam int READY_HOLDOFF = 2;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head reads as 0 while empty
// so downstream outputs stay quiet after reset.
module i2c_sync_fifo #(
    parameter int AW = 5,
    parameter int W  = 8
) (
    input  logic         CLK40,
    input  logic         rst_fifo,
    input  logic [W-1:0] din,
    input  logic         we,
    input  logic         re,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign do_wr = we && !full;
    assign do_rd = re && !empty;
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK40) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge CLK40 or posedge rst_fifo) begin
        if (rst_fifo) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_cmd_dispatch.sv
// Parses JTAG-fed command records, loads payload into the selected I2C port
// engines, fires EXECUTE and collects readback bytes.
module i2c_cmd_dispatch
    import i2c_dispatch_pkg::*;
#(
    parameter int N_PORTS   = 3,
    parameter int WFIFO_AW  = 5,
    parameter int RFIFO_AW  = 5,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 CLK40,
    input  logic                 rst_fifo,
    input  logic [7:0]           WFIFO_DIN,
    input  logic                 WFIFO_WE,
    input  logic                 RFIFO_RE,
    output logic [7:0]           RFIFO_DOUT,
    input  logic                 I2C_START,
    output logic                 CLR_START,
    output logic [7:0]           STATUS,
    output logic [N_PORTS-1:0]   ENG_SEL,
    output logic                 LOAD_N_BYTE,
    output logic [3:0]           N_BYTES,
    output logic                 READ,
    output logic                 LOAD_ADDR,
    output logic [3:0]           WRT_ADDR,
    output logic [7:0]           WRT_DATA,
    output logic                 WRT_ENA,
    output logic                 EXECUTE,
    input  logic [N_PORTS-1:0]   ENG_READY,
    input  logic [N_PORTS-1:0]   ENG_NACK,
    input  logic [N_PORTS-1:0]   ENG_RBK_WE,
    input  logic [8*N_PORTS-1:0] ENG_RBK_DATA
);

    localparam logic [8:0] ONE9      = 9'd1;
    localparam logic [7:0] PORT_MASK = 8'((ONE9 << N_PORTS) - ONE9);

    state_t                state, state_nx;
    logic [N_PORTS-1:0]    eng_sel;
    logic [3:0]            n_bytes;
    logic                  read_cmd;
    logic                  load_nb;
    logic [3:0]            wrt_addr;
    logic [TIMEOUT_W-1:0]  tmo_cnt;
    logic                  err_fmt, err_nack, err_tmo;

    logic [7:0] w_head;
    logic       w_full, w_empty, r_full, r_empty;
    logic       w_pop;
    logic       rbk_we;
    logic [7:0] rbk_data;

    logic head_bad, ready_ok;
    logic clr_err, set_fmt, set_nack, set_tmo, lat_sel, lat_nb;
    logic load_addr, wrt_ena, execute, clr_start;

    i2c_sync_fifo #(.AW(WFIFO_AW), .W(8)) u_wfifo (
        .CLK40    (CLK40),
        .rst_fifo (rst_fifo),
        .din      (WFIFO_DIN),
        .we       (WFIFO_WE),
        .re       (w_pop),
        .dout     (w_head),
        .full     (w_full),
        .empty    (w_empty)
    );

    i2c_sync_fifo #(.AW(RFIFO_AW), .W(8)) u_rfifo (
        .CLK40    (CLK40),
        .rst_fifo (rst_fifo),
        .din      (rbk_data),
        .we       (rbk_we),
        .re       (RFIFO_RE),
        .dout     (RFIFO_DOUT),
        .full     (r_full),
        .empty    (r_empty)
    );

    // Lowest-index selected port owns the readback path; iterate downward so it wins.
    always_comb begin
        rbk_we   = 1'b0;
        rbk_data = '0;
        for (int p = N_PORTS - 1; p >= 0; p--) begin
            if (eng_sel[p]) begin
                rbk_we   = ENG_RBK_WE[p];
                rbk_data = ENG_RBK_DATA[8*p +: 8];
            end
        end
    end

    assign head_bad = (w_head == 8'h00) || (|(w_head & ~PORT_MASK));
    assign ready_ok = (tmo_cnt >= TIMEOUT_W'(READY_HOLDOFF)) &&
                      ((ENG_READY & eng_sel) == eng_sel);

    always_comb begin
        state_nx  = state;
        w_pop     = 1'b0;
        clr_err   = 1'b0;
        set_fmt   = 1'b0;
        set_nack  = 1'b0;
        set_tmo   = 1'b0;
        lat_sel   = 1'b0;
        lat_nb    = 1'b0;
        load_addr = 1'b0;
        wrt_ena   = 1'b0;
        execute   = 1'b0;
        clr_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (I2C_START) begin
                    if (!w_empty) begin
                        clr_err  = 1'b1;
                        state_nx = S_LD_DEV;
                    end else begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_LD_DEV: begin
                w_pop = 1'b1;
                if (w_empty || head_bad) begin
                    set_fmt  = 1'b1;
                    state_nx = S_DRAIN;
                end else begin
                    lat_sel  = 1'b1;
                    state_nx = S_LD_NB;
                end
            end
            S_LD_NB: begin
                if (w_empty) begin
                    set_fmt  = 1'b1;
                    state_nx = S_DRAIN;
                end else begin
                    w_pop    = 1'b1;
                    lat_nb   = 1'b1;
                    state_nx = S_LD_ADDR;
                end
            end
            S_LD_ADDR: begin
                load_addr = 1'b1;
                state_nx  = read_cmd ? S_EXEC : S_LOAD;
            end
            S_LOAD: begin
                if (w_empty) begin
                    set_fmt  = 1'b1;
                    state_nx = S_DRAIN;
                end else begin
                    wrt_ena = 1'b1;
                    w_pop   = 1'b1;
                    // n_bytes of 0 wraps to 15 here, giving the 16-byte case.
                    if (wrt_addr == n_bytes - 4'd1) state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                execute  = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (ready_ok) begin
                    set_nack = |(ENG_NACK & eng_sel);
                    state_nx = w_empty ? S_DONE : S_LD_DEV;
                end else if (&tmo_cnt) begin
                    set_tmo  = 1'b1;
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_empty) state_nx = S_DONE;
                else         w_pop    = 1'b1;
            end
            S_DONE: begin
                clr_start = 1'b1;
                state_nx  = S_HOLD;
            end
            S_HOLD: begin
                if (!I2C_START) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK40 or posedge rst_fifo) begin
        if (rst_fifo) begin
            state    <= S_IDLE;
            eng_sel  <= '0;
            n_bytes  <= '0;
            read_cmd <= 1'b0;
            load_nb  <= 1'b0;
            wrt_addr <= '0;
            tmo_cnt  <= '0;
            err_fmt  <= 1'b0;
            err_nack <= 1'b0;
            err_tmo  <= 1'b0;
        end else begin
            state   <= state_nx;
            load_nb <= lat_nb;
            if (state == S_LD_DEV) eng_sel <= lat_sel ? w_head[N_PORTS-1:0] : '0;
            if (lat_nb) begin
                n_bytes  <= w_head[N_HI:N_LO];
                read_cmd <= w_head[READ_BIT];
            end
            if (load_addr)    wrt_addr <= '0;
            else if (wrt_ena) wrt_addr <= wrt_addr + 4'd1;
            if (execute)                            tmo_cnt <= '0;
            else if (state == S_WAIT && !(&tmo_cnt)) tmo_cnt <= tmo_cnt + 1'b1;
            if (clr_err) begin
                err_fmt  <= 1'b0;
                err_nack <= 1'b0;
                err_tmo  <= 1'b0;
            end else begin
                if (set_fmt)  err_fmt  <= 1'b1;
                if (set_nack) err_nack <= 1'b1;
                if (set_tmo)  err_tmo  <= 1'b1;
            end
        end
    end

    always_comb begin
        STATUS              = '0;
        STATUS[ST_BUSY]     = (state != S_IDLE);
        STATUS[ST_WEMPTY]   = w_empty;
        STATUS[ST_WFULL]    = w_full;
        STATUS[ST_REMPTY]   = r_empty;
        STATUS[ST_RFULL]    = r_full;
        STATUS[ST_ERR_FMT]  = err_fmt;
        STATUS[ST_ERR_NACK] = err_nack;
        STATUS[ST_ERR_TMO]  = err_tmo;
    end

    assign ENG_SEL     = eng_sel;
    assign LOAD_N_BYTE = load_nb;
    assign N_BYTES     = n_bytes;
    assign READ        = read_cmd;
    assign LOAD_ADDR   = load_addr;
    assign WRT_ADDR    = wrt_addr;
    assign WRT_DATA    = w_head;
    assign WRT_ENA     = wrt_ena;
    assign EXECUTE     = execute;
    assign CLR_START   = clr_start;

endmodule
